// File: rtl/mac_result_drain.sv
// Captures nine multiplier products in one cycle and drains them as single beats
// over a valid/ready stream. Define MAC_RESULT_DRAIN_SUM_EN to append a tenth beat carrying their sum.
module mac_result_drain #(
    parameter int NPROD = 9,
    parameter int PW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_valid,
    output logic          cap_ready,
    input  logic [PW-1:0] o1,
    input  logic [PW-1:0] o2,
    input  logic [PW-1:0] o3,
    input  logic [PW-1:0] o4,
    input  logic [PW-1:0] o5,
    input  logic [PW-1:0] o6,
    input  logic [PW-1:0] o7,
    input  logic [PW-1:0] o8,
    input  logic [PW-1:0] o9,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [8:0]    out_data,
    output logic [3:0]    out_idx,
    output logic          out_last
);

    localparam int DW = 9;
    localparam logic [3:0] NPROD_IDX = 4'(NPROD);
`ifdef MAC_RESULT_DRAIN_SUM_EN
    localparam logic [3:0] LAST_IDX = 4'd9;
`else
    localparam logic [3:0] LAST_IDX = 4'd8;
`endif

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, state_next;
    logic [PW-1:0] lanes  [NPROD];
    logic [PW-1:0] buffer [NPROD];
    logic [3:0]    idx;
    logic          capture;
    logic          beat_done;
    logic [DW-1:0] beat_data;

    always_comb begin
        lanes[0] = o1;
        lanes[1] = o2;
        lanes[2] = o3;
        lanes[3] = o4;
        lanes[4] = o5;
        lanes[5] = o6;
        lanes[6] = o7;
        lanes[7] = o8;
        lanes[8] = o9;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        cap_ready  = 1'b0;
        out_valid  = 1'b0;
        capture    = 1'b0;
        beat_done  = 1'b0;
        case (state)
            IDLE: begin
                cap_ready = 1'b1;
                if (cap_valid) begin
                    capture    = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    beat_done = 1'b1;
                    if (idx == LAST_IDX)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MAC_RESULT_DRAIN_SUM_EN
    logic [DW-1:0] sum, sum_next;

    // Nine 5-bit lanes peak at 279, so the 9-bit sum never overflows.
    always_comb begin
        sum_next = '0;
        for (int i = 0; i < NPROD; i++)
            sum_next = sum_next + {{(DW-PW){1'b0}}, lanes[i]};
    end

    always_ff @(posedge clk) begin
        if (rst)
            sum <= '0;
        else if (capture)
            sum <= sum_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= 4'd0;
            for (int i = 0; i < NPROD; i++)
                buffer[i] <= '0;
        end else if (capture) begin
            idx <= 4'd0;
            for (int i = 0; i < NPROD; i++)
                buffer[i] <= lanes[i];
        end else if (beat_done) begin
            idx <= (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
        end
    end

    always_comb begin
        beat_data = '0;
        if (idx < NPROD_IDX)
            beat_data = {{(DW-PW){1'b0}}, buffer[idx]};
`ifdef MAC_RESULT_DRAIN_SUM_EN
        else if (idx == LAST_IDX)
            beat_data = sum;
`endif
    end

    // idx parks at zero outside SEND, so the idle outputs read as all-zero.
    assign out_data = (state == SEND) ? beat_data : '0;
    assign out_idx  = idx;
    assign out_last = (state == SEND) && (idx == LAST_IDX);

endmodule

// File: tb/tb_mac_result_drain.sv
// Scoreboard bench for mac_result_drain: captures push expected beats, a negedge monitor
// compares every presented beat. Follows MAC_RESULT_DRAIN_SUM_EN for the beat count.
module tb_mac_result_drain;

`ifdef MAC_RESULT_DRAIN_SUM_EN
    localparam int NBEATS = 10;
`else
    localparam int NBEATS = 9;
`endif

    typedef struct packed {
        logic [8:0] data;
        logic [3:0] idx;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cap_valid = 1'b0;
    logic       cap_ready;
    logic [4:0] o [9];
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [8:0] out_data;
    logic [3:0] out_idx;
    logic       out_last;

    logic [4:0] stim [9];
    beat_t      exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         cycles;

    mac_result_drain #(.NPROD(9), .PW(5)) dut (
        .clk(clk), .rst(rst),
        .cap_valid(cap_valid), .cap_ready(cap_ready),
        .o1(o[0]), .o2(o[1]), .o3(o[2]), .o4(o[3]), .o5(o[4]),
        .o6(o[5]), .o7(o[6]), .o8(o[7]), .o9(o[8]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_all(input logic [4:0] v);
        for (int i = 0; i < 9; i++) stim[i] = v;
    endtask

    task automatic fill_seq(input logic [4:0] base);
        for (int i = 0; i < 9; i++) stim[i] = base + 5'(i);
    endtask

    task automatic drive_lanes();
        for (int i = 0; i < 9; i++) o[i] = stim[i];
    endtask

    task automatic push_expected();
        beat_t b;
        int    s;
        s = 0;
        for (int i = 0; i < 9; i++) begin
            b.data = {4'b0, stim[i]};
            b.idx  = 4'(i);
            b.last = (i == NBEATS - 1);
            exp_q.push_back(b);
            s += int'(stim[i]);
        end
`ifdef MAC_RESULT_DRAIN_SUM_EN
        b.data = 9'(s);
        b.idx  = 4'd9;
        b.last = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    // Capture stim in an IDLE cycle and confirm the first beat appears one cycle later.
    task automatic applyStimulus();
        checkOutput("cap_ready_before_capture", {15'b0, cap_ready}, 16'd1);
        drive_lanes();
        cap_valid = 1'b1;
        push_expected();
        wait_cycle();
        cap_valid = 1'b0;
        checkOutput("first_beat_valid", {15'b0, out_valid}, 16'd1);
        checkOutput("first_beat_idx", {12'b0, out_idx}, 16'd0);
    endtask

    // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0,1,0,0...
    task automatic drain(input int mode, output int ncyc);
        int k;
        k = 0;
        while (k < 60 && exp_q.size() > 0) begin
            out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            wait_cycle();
            k++;
        end
        out_ready = 1'b0;
        ncyc = k;
        checkOutput("drain_complete", 16'(exp_q.size()), 16'd0);
        checkOutput("idle_cap_ready", {15'b0, cap_ready}, 16'd1);
        checkOutput("idle_out_valid", {15'b0, out_valid}, 16'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat actual_idx=%0d actual_data=%0d required=no_beat", out_idx, out_data);
            end else begin
                checkOutput("beat_data", {7'b0, out_data}, {7'b0, exp_q[0].data});
                checkOutput("beat_idx", {12'b0, out_idx}, {12'b0, exp_q[0].idx});
                checkOutput("beat_last", {15'b0, out_last}, {15'b0, exp_q[0].last});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 9; i++) o[i] = 5'd0;
        repeat (3) wait_cycle();
        rst = 1'b0;
        checkOutput("reset_cap_ready", {15'b0, cap_ready}, 16'd1);
        checkOutput("reset_out_valid", {15'b0, out_valid}, 16'd0);
        checkOutput("reset_out_data", {7'b0, out_data}, 16'd0);
        checkOutput("reset_out_idx", {12'b0, out_idx}, 16'd0);
        checkOutput("reset_out_last", {15'b0, out_last}, 16'd0);

        // out_ready in IDLE must not produce anything.
        out_ready = 1'b1;
        wait_cycle();
        out_ready = 1'b0;
        checkOutput("idle_ready_no_valid", {15'b0, out_valid}, 16'd0);

        $display("[TB] basic drain, all lanes 4");
        fill_all(5'd4);
        applyStimulus();
        drain(0, cycles);
        checkOutput("basic_beat_cycles", 16'(cycles), 16'(NBEATS));

        $display("[TB] backpressure, lanes 1..9");
        fill_seq(5'd1);
        applyStimulus();
        drain(1, cycles);

        $display("[TB] capture held high during SEND");
        fill_seq(5'd10);
        applyStimulus();
        fill_seq(5'd20);
        drive_lanes();
        cap_valid = 1'b1;
        checkOutput("cap_ready_in_send", {15'b0, cap_ready}, 16'd0);
        drain(0, cycles);
        applyStimulus();
        drain(0, cycles);

        $display("[TB] reset mid-transfer");
        fill_all(5'd7);
        applyStimulus();
        out_ready = 1'b1;
        repeat (4) wait_cycle();
        checkOutput("pre_reset_idx", {12'b0, out_idx}, 16'd4);
        rst = 1'b1;
        cap_valid = 1'b1;
        wait_cycle();
        exp_q.delete();
        rst = 1'b0;
        cap_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("mid_reset_out_valid", {15'b0, out_valid}, 16'd0);
        checkOutput("mid_reset_cap_ready", {15'b0, cap_ready}, 16'd1);
        checkOutput("mid_reset_out_idx", {12'b0, out_idx}, 16'd0);
        checkOutput("mid_reset_out_data", {7'b0, out_data}, 16'd0);
        checkOutput("mid_reset_out_last", {15'b0, out_last}, 16'd0);
        fill_seq(5'd3);
        applyStimulus();
        drain(0, cycles);

        $display("[TB] all lanes 31");
        fill_all(5'd31);
        applyStimulus();
        drain(0, cycles);
        checkOutput("max_beat_cycles", 16'(cycles), 16'(NBEATS));
        wait_cycle();
        checkOutput("no_extra_beat_valid", {15'b0, out_valid}, 16'd0);
        checkOutput("no_extra_beat_idx", {12'b0, out_idx}, 16'd0);

        repeat (2) wait_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_result_drain.md
MAC_RESULT_DRAIN -- requirements
Module: mac_result_drain

Interface
REQ-001 SHALL have parameter NPROD, default 9; number of product lanes captured per transfer, fixed at 9 for this release.
REQ-002 SHALL have parameter PW, default 5; width of each product lane.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port cap_valid  input  1  the nine products on o1..o9 are valid this cycle.
REQ-006 SHALL have port cap_ready  output  1  the block can accept a capture this cycle.
REQ-007 SHALL have ports o1..o9  input  5 each  product lanes driven by the multip array.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid beat.
REQ-009 SHALL have port out_ready  input  1  the downstream sink accepts the current beat.
REQ-010 SHALL have port out_data  output  9  beat payload; product beats are zero-extended to 9 bits.
REQ-011 SHALL have port out_idx  output  4  beat index: 0..8 for products, 9 for the sum beat.
REQ-012 SHALL have port out_last  output  1  asserted on the final beat of a transfer.

Function
REQ-013 SHALL implement an FSM with two states: IDLE and SEND.
REQ-014 In IDLE, SHALL drive cap_ready=1 and out_valid=0.
REQ-015 On cap_valid & cap_ready, SHALL register o1..o9 into an internal buffer, set idx=0, and enter SEND on the next cycle.
REQ-016 Capture-to-first-beat latency SHALL be one cycle: out_valid=1 with idx 0 in the cycle after capture.
REQ-017 In SEND, SHALL drive cap_ready=0 and ignore cap_valid; no capture occurs and o1..o9 changes have no effect.
REQ-018 In SEND, SHALL drive out_valid=1, out_data=buffer[idx] and out_idx=idx.
REQ-019 A beat SHALL transfer only when out_valid & out_ready are both 1, after which idx increments.
REQ-020 While out_ready=0, out_data, out_idx and out_last SHALL remain stable.
REQ-021 out_last SHALL be 1 only when idx equals the final index: 8, or 9 with DRAIN_SUM_EN.
REQ-022 When the last beat transfers, SHALL return to IDLE with cap_ready=1 in the next cycle.
REQ-023 Minimum spacing between successive captures SHALL be (beats + 1) cycles; the idle cycle after the last beat is mandatory.
REQ-024 idx SHALL never wrap past the final index.
REQ-025 out_ready=1 while in IDLE SHALL have no effect.

Reset
REQ-026 When rst=1 at a clock edge, SHALL enter IDLE with idx=0, buffer and sum cleared, out_valid=0, out_last=0, out_data=0, out_idx=0 and cap_ready=1 from the next cycle.
REQ-027 Reset during SEND SHALL discard the in-flight transfer; no further beats of that transfer are emitted.
REQ-028 rst SHALL take priority over simultaneous cap_valid or out_ready.

Configuration
REQ-029 The macro MAC_RESULT_DRAIN_SUM_EN SHALL control the sum beat; when defined, the sum of all nine products (9-bit, max 9*31=279, no overflow) SHALL be registered at capture time.
REQ-030 With MAC_RESULT_DRAIN_SUM_EN defined, a tenth beat SHALL be sent with out_idx=9, carrying the registered sum and with out_last=1.
REQ-031 With MAC_RESULT_DRAIN_SUM_EN undefined, each transfer SHALL be exactly 9 beats, with out_last on idx 8, no sum register and no adder logic.

Verification
REQ-032 Bench SHALL check basic drain: rst, then a capture with all o=4 and out_ready=1 -> beats idx 0..8 each with data 4 on consecutive cycles, out_last on idx 8, then cap_ready=1 on the next cycle.
REQ-033 Bench SHALL check backpressure: o1..o9=1..9, out_ready toggling 1,0,0,1... -> data sequence 1..9 with no loss or duplication, and payload stable during stalls.
REQ-034 Bench SHALL check ignored capture: cap_valid held high during SEND with new o values -> beats still carry the first captured set, and a second capture is accepted only after the IDLE cycle.
REQ-035 Bench SHALL check reset mid-transfer: rst asserted after beat 3 -> out_valid=0 next cycle, cap_ready=1, and a new capture drains starting from idx 0.
REQ-036 Bench SHALL check the sum beat with MAC_RESULT_DRAIN_SUM_EN defined: all o=4 -> tenth beat idx 9 with data 36 and out_last=1; all o=31 -> tenth beat data 279.
REQ-037 Bench SHALL check the build without MAC_RESULT_DRAIN_SUM_EN: all o=31 -> exactly 9 beats, with no beat at idx 9.
